// File: rtl/avalon_pio_bank.sv
// avalon_pio_bank: one Avalon-MM slave combining switch input, debounced
// button input with press-edge capture and a maskable interrupt, and an LED
// output register with atomic set/clear aliases.
//
// Bus protocol: an access happens only on a cycle where chipselect is high.
// A write takes effect on that clock edge. A read (read & ~write) is answered
// on the next cycle on readdata, which then holds until the next read. There
// is no waitrequest, so the master may issue an access every cycle. If read
// and write are both high, the write wins and readdata is left unchanged.
module avalon_pio_bank #(
  parameter int N_SW            = 9,
  parameter int N_BTN           = 4,
  parameter int N_LED           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [N_SW-1:0]   switches,
  input  logic [N_BTN-1:0]  buttons,
  output logic [N_LED-1:0]  leds
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw button level that means "not pressed"; synchroniser resets to it.
  localparam logic [N_BTN-1:0] BTN_IDLE = {N_BTN{(BTN_ACTIVE_LOW != 0)}};

  localparam logic [2:0] A_SW = 3'd0, A_BTN = 3'd1, A_LED = 3'd2,
                         A_SET = 3'd3, A_CLR = 3'd4, A_EDGE = 3'd5,
                         A_MASK = 3'd6, A_ID = 3'd7;

  logic [N_SW-1:0]  sw_meta, sw_sync;
  logic [N_BTN-1:0] btn_meta, btn_sync;
  logic [N_BTN-1:0] pressed_sync;
  logic [N_BTN-1:0] stable;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] edge_cap, mask;
  logic [N_BTN-1:0] edge_clr;
  logic [N_LED-1:0] led_r;
  logic [31:0]      rdata_mux;
  logic             wr_en, rd_en;
  logic             unused_wd;

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read & ~write;
  assign pressed_sync = (BTN_ACTIVE_LOW != 0) ? ~btn_sync : btn_sync;
  assign leds         = led_r;
  assign unused_wd    = ^writedata;

  // Two-flop synchronisers for all board inputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= BTN_IDLE;
      btn_sync <= BTN_IDLE;
    end else begin
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
      btn_meta <= buttons;
      btn_sync <= btn_meta;
    end
  end

  // Per-button debounce: accept a new level after it differs for the full window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stable <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (pressed_sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= pressed_sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press detection: the edge on which stable goes not-pressed -> pressed.
  always_comb begin
    press = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (pressed_sync[i] && !stable[i] && cnt[i] == LAST) press[i] = 1'b1;
    end
  end

  // W1C clear mask from a write to the EDGE register.
  always_comb begin
    edge_clr = '0;
    if (wr_en && address == A_EDGE) edge_clr = writedata[N_BTN-1:0];
  end

  // Register file: LED with set/clear aliases, edge capture (set beats clear), mask, irq.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      led_r    <= '0;
      edge_cap <= '0;
      mask     <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | press;
      irq      <= |(edge_cap & mask);
      if (wr_en) begin
        case (address)
          A_LED:   led_r <= writedata[N_LED-1:0];
          A_SET:   led_r <= led_r | writedata[N_LED-1:0];
          A_CLR:   led_r <= led_r & ~writedata[N_LED-1:0];
          A_MASK:  mask  <= writedata[N_BTN-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read multiplexer; unused high bits and write-only registers read as zero.
  always_comb begin
    rdata_mux = '0;
    case (address)
      A_SW:    rdata_mux[N_SW-1:0]  = sw_sync;
      A_BTN:   rdata_mux[N_BTN-1:0] = stable;
      A_LED:   rdata_mux[N_LED-1:0] = led_r;
      A_SET:   rdata_mux = '0;
      A_CLR:   rdata_mux = '0;
      A_EDGE:  rdata_mux[N_BTN-1:0] = edge_cap;
      A_MASK:  rdata_mux[N_BTN-1:0] = mask;
      A_ID:    rdata_mux = {8'h0, 8'(N_BTN), 8'(N_SW), 8'(N_LED)};
      default: rdata_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rdata_mux;
    end
  end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Testbench for avalon_pio_bank: directed scenarios plus a randomized phase,
// checked against a cycle-level behavioural model through a read scoreboard.
module tb_avalon_pio_bank;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic        cs, rd, wr;
  logic [31:0] wd;
  logic [31:0] readdata;
  logic        irq;
  logic [8:0]  switches;
  logic [3:0]  buttons;
  logic [7:0]  leds;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  avalon_pio_bank #(
    .N_SW(9), .N_BTN(4), .N_LED(8), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1)
  ) dut (
    .Clk(clk), .Reset(rst), .address(addr), .chipselect(cs), .read(rd),
    .write(wr), .writedata(wd), .readdata(readdata), .irq(irq),
    .switches(switches), .buttons(buttons), .leds(leds)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Pins reach the logic two edges late; a button level is accepted once it
  // has disagreed with the accepted state for DEB consecutive edges.
  bit [8:0] m_sw1, m_sw2;
  bit [3:0] m_bp1, m_bp2;
  bit [3:0] m_stable, m_edge, m_mask, m_nstable, m_rise, m_clr;
  bit [7:0] m_led;
  bit       m_irq;
  bit       m_rd_pending;
  int       m_run [4];

  function automatic logic [31:0] model_view(input logic [2:0] a);
    case (a)
      3'd0: return {23'h0, m_sw2};
      3'd1: return {28'h0, m_stable};
      3'd2: return {24'h0, m_led};
      3'd5: return {28'h0, m_edge};
      3'd6: return {28'h0, m_mask};
      3'd7: return 32'h0004_0908;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_sw1 = '0; m_sw2 = '0; m_bp1 = '0; m_bp2 = '0;
      m_stable = '0; m_edge = '0; m_mask = '0; m_led = '0; m_irq = 1'b0;
      m_rd_pending = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      exp_q.delete();
    end else begin
      m_rd_pending = 1'b0;
      if (cs && rd && !wr) begin
        exp_q.push_back(model_view(addr));
        m_rd_pending = 1'b1;
      end
      m_nstable = m_stable;
      for (int i = 0; i < 4; i++) begin
        if (m_bp2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_nstable[i] = m_bp2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_rise = m_nstable & ~m_stable;
      m_clr  = (cs && wr && addr == 3'd5) ? wd[3:0] : 4'h0;
      m_irq  = |(m_edge & m_mask);
      m_edge = (m_edge & ~m_clr) | m_rise;
      if (cs && wr) begin
        case (addr)
          3'd2: m_led = wd[7:0];
          3'd3: m_led = m_led | wd[7:0];
          3'd4: m_led = m_led & ~wd[7:0];
          3'd6: m_mask = wd[3:0];
          default: ;
        endcase
      end
      m_stable = m_nstable;
      m_bp2 = m_bp1; m_bp1 = ~buttons;
      m_sw2 = m_sw1; m_sw1 = switches;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs 1 time unit after each active edge.
  always begin
    @(posedge clk);
    #1;
    check("leds", {24'h0, leds}, {24'h0, m_led});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    if (m_rd_pending) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [2:0] a);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wd = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
    switches = '0; buttons = 4'hF;
    idle(3);
    rst = 1'b0;
    check("rst_readdata", readdata, 32'h0);
    check("rst_leds", {24'h0, leds}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // ID register
    do_read(3'd7);
    check("id", readdata, 32'h0004_0908);

    // LED register and aliases
    do_write(3'd2, 32'hA5);
    check("led_write", {24'h0, leds}, 32'hA5);
    do_write(3'd3, 32'h0A);
    check("led_set", {24'h0, leds}, 32'hAF);
    do_write(3'd4, 32'h81);
    check("led_clr", {24'h0, leds}, 32'h2E);
    do_read(3'd2);
    check("led_read", readdata, 32'h2E);
    do_read(3'd3);
    check("led_set_read", readdata, 32'h0);

    // Glitch shorter than the debounce window
    buttons[1] = 1'b0;
    idle(10);
    buttons[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      do_read(3'd1);
      do_read(3'd5);
    end
    check("glitch_edge", readdata, 32'h0);

    // Held press: accepted on the 18th edge after the pin falls
    buttons[1] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      do_read(3'd1);
      if (k == 18) check("btn_lat_before", {31'h0, readdata[1]}, 32'h0);
      if (k == 19) check("btn_lat_after", {31'h0, readdata[1]}, 32'h1);
    end
    do_read(3'd5);
    check("edge_after_press", readdata, 32'h2);
    buttons[1] = 1'b1;
    idle(20);

    // Interrupt enable and W1C
    do_write(3'd6, 32'h2);
    idle(2);
    check("irq_set", {31'h0, irq}, 32'h1);
    do_write(3'd5, 32'h2);
    idle(1);
    check("irq_clear", {31'h0, irq}, 32'h0);
    do_read(3'd5);
    check("edge_cleared", readdata, 32'h0);

    // Masked press: EDGE sets, irq stays low
    do_write(3'd6, 32'h0);
    buttons[0] = 1'b0;
    idle(25);
    do_read(3'd5);
    check("masked_edge", readdata, 32'h1);
    check("masked_irq", {31'h0, irq}, 32'h0);
    buttons[0] = 1'b1;
    idle(20);
    do_write(3'd5, 32'hF);

    // W1C on the very edge button 2 becomes pressed: set wins
    buttons[2] = 1'b0;
    idle(17);
    do_write(3'd5, 32'h4);
    do_read(3'd5);
    check("set_beats_clear", readdata, 32'h4);
    buttons[2] = 1'b1;
    idle(20);
    do_write(3'd5, 32'hF);

    // Switches
    switches = 9'h1C3;
    idle(2);
    do_read(3'd0);
    check("switches", readdata, 32'h1C3);

    // Reset in the middle of a debounce window restarts it
    buttons[3] = 1'b0;
    idle(12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_leds", {24'h0, leds}, 32'h0);
    for (int k = 1; k <= 25; k++) begin
      do_read(3'd1);
      if (k == 18) check("midrst_before", {31'h0, readdata[3]}, 32'h0);
      if (k == 19) check("midrst_after", {31'h0, readdata[3]}, 32'h1);
    end
    buttons[3] = 1'b1;
    idle(20);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int op;
      if ($urandom_range(0, 11) == 0) buttons[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) switches = 9'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      op = $urandom_range(0, 2);
      cs = (op != 0) || ($urandom_range(0, 3) == 0);
      rd = (op == 1);
      wr = (op == 2);
      addr = 3'($urandom_range(0, 7));
      wd = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    idle(3);
    check("exp_q_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bank.md
# avalon_pio_bank

Parametrised Avalon-MM parallel-I/O peripheral for the Nios II system. It replaces separate switch, button and LED PIO instances with one slave. It synchronises and debounces board inputs, captures button press edges with a maskable interrupt, and drives a read/write LED register with atomic set/clear aliases. It sits inside the SoC, attached to the Nios II data master, with its conduit pins routed to the board switches, KEYs and LEDs at the top level.

## Interface
Parameters:
- N_SW, 9: switch input width (1..32).
- N_BTN, 4: button input width (1..32).
- N_LED, 8: LED output width (1..32).
- DEBOUNCE_CYCLES, 500000: cycles a synchronised button level must hold before it is accepted (≥2).
- BTN_ACTIVE_LOW, 1: 1 means a physical low level is "pressed".

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.
- switches  in  N_SW  raw switch pins.
- buttons  in  N_BTN  raw button pins.
- leds  out  N_LED  LED drive, equal to the LED register.

## Operation
- Register map (unused high bits read 0; writes to RO registers are ignored):
  - 0 SW (RO): synchronised switches.
  - 1 BTN (RO): debounced button state, 1 = pressed, polarity applied.
  - 2 LED (RW): full write.
  - 3 LED_SET (WO): LED |= wd.
  - 4 LED_CLR (WO): LED &= ~wd.
  - 5 EDGE (R/W1C): press-capture bits.
  - 6 MASK (RW): interrupt enable per button.
  - 7 ID (RO): {8'h0, N_BTN[7:0], N_SW[7:0], N_LED[7:0]}.
- Reads of WO registers return 0.
- Access qualifiers: an access occurs only when chipselect is high. read and write asserted together is illegal; on that cycle the write takes effect and readdata is unspecified.
- Input synchroniser: every switch and button bit passes through a 2-flop synchroniser. Synchroniser flops reset to the inactive level: switches 0; buttons 1 if BTN_ACTIVE_LOW, else 0.
- Debounce, per button:
  - Counter width $clog2(DEBOUNCE_CYCLES).
  - If sync == stable, the counter clears.
  - Otherwise the counter increments. On the cycle where the counter equals DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge capture: EDGE[i] sets on the clock edge where stable[i] goes from not-pressed to pressed. Releases do not set EDGE.
- W1C: a write to EDGE clears the bits where writedata is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq = |(EDGE & MASK), registered.
- LED: write, set or clear takes effect on the clock edge of the write; leds follows the LED register directly.

## Timing
- Reset values: readdata 0, irq 0, leds 0, LED 0, EDGE 0, MASK 0, debounce counters 0.
- Stable button state resets to not-pressed.
- Reset asserted mid-debounce or mid-access discards all in-flight state. The first access after Reset deasserts is legal on the following cycle.
- Read latency is 1: readdata is valid the cycle after read & chipselect and holds until the next read. No waitrequest.
- Write latency: the register updates at the write edge and is readable by a read issued on the next cycle.
- Button-to-BTN latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles after the pin changes. EDGE sets on that same edge.
- irq rises 1 cycle after EDGE&MASK becomes nonzero and falls 1 cycle after it becomes zero.
- Switch latency: 2 cycles, no debounce.

## Test plan
- Reset and ID: assert Reset 3 cycles.
  - leds=0, irq=0, readdata=0.
  - With N_SW=9, N_BTN=4, N_LED=8, reading addr 7 returns 32'h00040908.
- LED aliases:
  - Write LED=8'hA5 → leds=8'hA5.
  - LED_SET 8'h0A → 8'hAF.
  - LED_CLR 8'h81 → 8'h2E.
  - Reading addr 2 returns 32'h2E; reading addr 3 returns 0.
- Debounce (DEBOUNCE_CYCLES=16, active-low):
  - Pulse buttons[1] low for 10 cycles → BTN and EDGE stay 0.
  - Hold it low 40 cycles → BTN[1]=1 exactly 18 cycles after the pin falls, and EDGE=4'b0010.
- Interrupt:
  - MASK=4'b0010 with EDGE[1] set → irq=1 next cycle.
  - W1C writedata=4'b0010 → EDGE=0 and irq=0 one cycle later.
  - With MASK=0, a press sets EDGE but irq stays 0.
- Simultaneous set/clear: W1C EDGE[2] on the exact cycle button 2 becomes stable-pressed → EDGE[2] remains 1.
- Switches and reset mid-debounce:
  - Switches=9'h1C3 → addr 0 reads 32'h1C3 after ≥2 cycles + 1 read cycle.
  - Assert Reset while the counter is at 10 → after release, the button needs a full 16 cycles again.
